mult_seq_param: RTL and testbench

Parametrised sequential shift-add multiplier: datapath plus control FSM in one block. Multiplies two WIDTH-bit operands into a 2·WIDTH-bit product. Supports unsigned and two's-complement signed modes, selectable per operation, and ends early once the remaining multiplier bits are zero. It sits in the calculator datapath behind the operand registers, with a start/busy/done handshake to the top-level calculator controller.

---
 rtl/mult_seq_param.sv | 151 +++++++++++++++
 tb/tb_mult_seq_param.sv | 358 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mult_seq_param.sv
// mult_seq_param
// Sequential shift-add multiplier with its control FSM in one block.
// Multiplies two WIDTH-bit operands into a 2*WIDTH-bit product, in either
// unsigned or two's-complement signed mode (chosen per operation). The core
// works on magnitudes and fixes up the sign at the end. The add-and-shift
// loop stops early once no set multiplier bits remain.
//
// Ports:
//   clk          system clock, rising edge
//   reset_n      synchronous active-low reset
//   start        operation request, accepted only while idle
//   signed_mode  1 = two's complement operands, 0 = unsigned (captured on accept)
//   operand_a    multiplicand (captured on accept)
//   operand_b    multiplier (captured on accept)
//   busy         high while an operation is in flight (LOAD, CALC, SIGN)
//   done         one-cycle completion pulse
//   product      registered result, held until the next result is written
module mult_seq_param #(
  parameter int WIDTH = 8
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic               start,
  input  logic               signed_mode,
  input  logic [WIDTH-1:0]   operand_a,
  input  logic [WIDTH-1:0]   operand_b,
  output logic               busy,
  output logic               done,
  output logic [2*WIDTH-1:0] product
);

  localparam int PW = 2 * WIDTH;
  localparam int CW = $clog2(WIDTH + 1);

  localparam logic [CW-1:0]    COUNT_INIT = CW'(WIDTH);
  localparam logic [CW-1:0]    COUNT_ONE  = CW'(1);
  localparam logic [WIDTH-1:0] ONE_W      = WIDTH'(1);
  localparam logic [PW-1:0]    ONE_P      = PW'(1);

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    CALC,
    SIGN,
    DONE_ST
  } state_t;

  state_t state;

  // Operands and mode as captured at the accept edge
  logic [WIDTH-1:0] a_reg;
  logic [WIDTH-1:0] b_reg;
  logic             mode_reg;

  // Datapath registers
  logic [PW-1:0]    shift_a;
  logic [WIDTH-1:0] shift_b;
  logic [PW-1:0]    acc;
  logic [CW-1:0]    count;
  logic             neg;

  // Magnitudes of the captured operands. The most negative value maps to
  // 2^(WIDTH-1), which still fits in WIDTH unsigned bits, so no extra bit.
  logic [WIDTH-1:0] mag_a;
  logic [WIDTH-1:0] mag_b;
  logic [WIDTH-1:0] b_after_shift;

  always_comb begin
    mag_a = a_reg;
    mag_b = b_reg;
    if (mode_reg && a_reg[WIDTH-1]) begin
      mag_a = ~a_reg + ONE_W;
    end
    if (mode_reg && b_reg[WIDTH-1]) begin
      mag_b = ~b_reg + ONE_W;
    end
    b_after_shift = shift_b >> 1;
  end

  // Control FSM and datapath. busy/done are registered alongside the state
  // so they carry no combinational path from the inputs.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state    <= IDLE;
      busy     <= 1'b0;
      done     <= 1'b0;
      product  <= '0;
      a_reg    <= '0;
      b_reg    <= '0;
      mode_reg <= 1'b0;
      shift_a  <= '0;
      shift_b  <= '0;
      acc      <= '0;
      count    <= '0;
      neg      <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            a_reg    <= operand_a;
            b_reg    <= operand_b;
            mode_reg <= signed_mode;
            busy     <= 1'b1;
            state    <= LOAD;
          end
        end

        LOAD: begin
          shift_a <= {{WIDTH{1'b0}}, mag_a};
          shift_b <= mag_b;
          acc     <= '0;
          count   <= COUNT_INIT;
          neg     <= mode_reg & (a_reg[WIDTH-1] ^ b_reg[WIDTH-1]);
          state   <= CALC;
        end

        CALC: begin
          if (shift_b[0]) begin
            acc <= acc + shift_a;
          end
          shift_a <= shift_a << 1;
          shift_b <= b_after_shift;
          count   <= count - COUNT_ONE;
          // Leave as soon as no set multiplier bits remain after this step
          if ((count == COUNT_ONE) || (b_after_shift == '0)) begin
            state <= SIGN;
          end
        end

        SIGN: begin
          product <= neg ? (~acc + ONE_P) : acc;
          busy    <= 1'b0;
          done    <= 1'b1;
          state   <= DONE_ST;
        end

        DONE_ST: begin
          done  <= 1'b0;
          state <= IDLE;
        end

        default: begin
          busy  <= 1'b0;
          done  <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mult_seq_param.sv
// Testbench for mult_seq_param. Drives an 8-bit and a 16-bit instance from
// shared stimulus signals and compares against an arithmetic reference model.
module tb_mult_seq_param;

  logic        clk;
  logic        reset_n;
  logic        start;
  logic        sel16;
  logic        smode;
  logic [15:0] op_a;
  logic [15:0] op_b;

  logic        start8;
  logic        start16;
  logic        busy8;
  logic        done8;
  logic [15:0] product8;
  logic        busy16;
  logic        done16;
  logic [31:0] product16;

  logic        busy_m;
  logic        done_m;
  logic [31:0] product_m;

  int checks;
  int errors;
  logic [15:0] last_exp8;

  assign start8    = start & ~sel16;
  assign start16   = start & sel16;
  assign busy_m    = sel16 ? busy16 : busy8;
  assign done_m    = sel16 ? done16 : done8;
  assign product_m = sel16 ? product16 : {16'h0000, product8};

  mult_seq_param #(.WIDTH(8)) dut8 (
    .clk         (clk),
    .reset_n     (reset_n),
    .start       (start8),
    .signed_mode (smode),
    .operand_a   (op_a[7:0]),
    .operand_b   (op_b[7:0]),
    .busy        (busy8),
    .done        (done8),
    .product     (product8)
  );

  mult_seq_param #(.WIDTH(16)) dut16 (
    .clk         (clk),
    .reset_n     (reset_n),
    .start       (start16),
    .signed_mode (smode),
    .operand_a   (op_a),
    .operand_b   (op_b),
    .busy        (busy16),
    .done        (done16),
    .product     (product16)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference: signed/unsigned integer product truncated to 2*w bits
  function automatic logic [31:0] ref_product(input int w, input logic [15:0] a,
                                              input logic [15:0] b, input bit sm);
    longint full, sa, sb, p;
    full = longint'(1) << w;
    sa = longint'(a) & (full - 1);
    sb = longint'(b) & (full - 1);
    if (sm && sa >= full / 2) sa = sa - full;
    if (sm && sb >= full / 2) sb = sb - full;
    p = sa * sb;
    return 32'(p & ((longint'(1) << (2 * w)) - 1));
  endfunction

  // Reference: number of add-shift cycles = position of highest set bit of |b| + 1
  function automatic int ref_cycles(input int w, input logic [15:0] b, input bit sm);
    longint full, mb;
    int n;
    full = longint'(1) << w;
    mb = longint'(b) & (full - 1);
    if (sm && mb >= full / 2) mb = full - mb;
    n = 1;
    for (int i = 0; i < w; i++) begin
      if (((mb >> i) & 1) == 1) n = i + 1;
    end
    return n;
  endfunction

  // One full operation; optionally pokes start while busy and in DONE_ST,
  // and scrambles the inputs after the accept edge.
  task automatic do_op(input bit w16, input logic [15:0] a, input logic [15:0] b,
                       input bit sm, input bit poke, input string name);
    int w;
    int n;
    int done_cyc;
    int busy_err;
    logic [31:0] exp;
    logic [31:0] got;
    w = w16 ? 16 : 8;
    n = ref_cycles(w, b, sm);
    exp = ref_product(w, a, b, sm);
    done_cyc = 0;
    busy_err = 0;
    got = '0;
    sel16 = w16;
    op_a = a;
    op_b = b;
    smode = sm;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    if (poke) begin
      op_a = 16'($urandom);
      op_b = 16'($urandom);
      smode = ~sm;
    end
    for (int k = 1; k <= w + 6; k++) begin
      if (poke && k == 3) start = 1'b1;
      if (poke && k == 4) start = 1'b0;
      if (busy_m !== (k <= n + 2)) busy_err++;
      if (done_m === 1'b1) begin
        done_cyc = k;
        got = product_m;
        break;
      end
      @(posedge clk); #1;
    end
    checks++;
    if (done_cyc != n + 3) begin
      errors++;
      $display("[TB] FAIL %s done_cycle: got %0d expected %0d", name, done_cyc, n + 3);
    end
    checks++;
    if (got !== exp) begin
      errors++;
      $display("[TB] FAIL %s product: got %h expected %h", name, got, exp);
    end
    checks++;
    if (busy_err != 0) begin
      errors++;
      $display("[TB] FAIL %s busy_profile: got %0d bad cycles expected 0", name, busy_err);
    end
    if (poke) begin
      start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      @(posedge clk); #1;
      checks++;
      if (busy_m !== 1'b0) begin
        errors++;
        $display("[TB] FAIL %s start_ignored_in_done: busy got %b expected 0", name, busy_m);
      end
    end else begin
      @(posedge clk); #1;
    end
    checks++;
    if (product_m !== exp) begin
      errors++;
      $display("[TB] FAIL %s product_hold: got %h expected %h", name, product_m, exp);
    end
    if (!w16) last_exp8 = exp[15:0];
  endtask

  task automatic test_reset();
    checks++;
    if ({busy8, done8, product8} !== 18'h0) begin
      errors++;
      $display("[TB] FAIL reset_w8: got busy=%b done=%b product=%h expected 0/0/0",
               busy8, done8, product8);
    end
    checks++;
    if ({busy16, done16, product16} !== 34'h0) begin
      errors++;
      $display("[TB] FAIL reset_w16: got busy=%b done=%b product=%h expected 0/0/0",
               busy16, done16, product16);
    end
  endtask

  task automatic test_unsigned_basic();
    do_op(1'b0, 16'd13, 16'd11, 1'b0, 1'b0, "u13x11");
  endtask

  task automatic test_signed();
    do_op(1'b0, 16'h0080, 16'h0080, 1'b1, 1'b0, "s_m128xm128");
    do_op(1'b0, 16'h00FB, 16'h0007, 1'b1, 1'b0, "s_m5x7");
    do_op(1'b0, 16'h0003, 16'h00FF, 1'b1, 1'b0, "s_3xm1");
  endtask

  task automatic test_early_termination();
    do_op(1'b0, 16'h00FF, 16'h0000, 1'b0, 1'b0, "u255x0");
    do_op(1'b0, 16'h00FF, 16'h00FF, 1'b0, 1'b0, "u255x255");
  endtask

  task automatic test_reset_mid_op();
    int done_seen;
    do_op(1'b0, 16'd13, 16'd11, 1'b0, 1'b0, "pre_reset");
    sel16 = 1'b0;
    op_a = 16'h00FF;
    op_b = 16'h00FF;
    smode = 1'b0;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    reset_n = 1'b0;
    @(posedge clk); #1;
    checks++;
    if ({busy8, done8, product8} !== 18'h0) begin
      errors++;
      $display("[TB] FAIL reset_mid_op: got busy=%b done=%b product=%h expected 0/0/0",
               busy8, done8, product8);
    end
    reset_n = 1'b1;
    done_seen = 0;
    for (int k = 0; k < 14; k++) begin
      if (done8 === 1'b1 || busy8 === 1'b1) done_seen++;
      @(posedge clk); #1;
    end
    checks++;
    if (done_seen != 0) begin
      errors++;
      $display("[TB] FAIL reset_abort_quiet: got %0d active cycles expected 0", done_seen);
    end
    do_op(1'b0, 16'd3, 16'd2, 1'b0, 1'b0, "post_reset_3x2");
  endtask

  task automatic test_handshake();
    do_op(1'b0, 16'd200, 16'd93, 1'b0, 1'b1, "poke_u200x93");
    do_op(1'b0, 16'h00F0, 16'h0039, 1'b1, 1'b1, "poke_s");
  endtask

  task automatic test_back_to_back();
    logic [15:0] ta [3];
    logic [15:0] tb [3];
    bit          ts [3];
    int t;
    int last_t;
    int ndone;
    int hold_err;
    int n;
    logic [31:0] exp;
    ta[0] = 16'd13;   tb[0] = 16'd11;   ts[0] = 1'b0;
    ta[1] = 16'h00FB; tb[1] = 16'h0007; ts[1] = 1'b1;
    ta[2] = 16'd200;  tb[2] = 16'd0;    ts[2] = 1'b0;
    t = 0;
    last_t = 0;
    ndone = 0;
    hold_err = 0;
    sel16 = 1'b0;
    op_a = ta[0];
    op_b = tb[0];
    smode = ts[0];
    start = 1'b1;
    while (ndone < 3 && t < 200) begin
      @(posedge clk); #1;
      t++;
      if (done8 === 1'b1) begin
        n = ref_cycles(8, tb[ndone], ts[ndone]);
        exp = ref_product(8, ta[ndone], tb[ndone], ts[ndone]);
        checks++;
        if (product8 !== exp[15:0]) begin
          errors++;
          $display("[TB] FAIL b2b_product%0d: got %h expected %h", ndone, product8, exp[15:0]);
        end
        checks++;
        if ((ndone == 0 && t != n + 3) || (ndone > 0 && t - last_t != n + 4)) begin
          errors++;
          $display("[TB] FAIL b2b_spacing%0d: got %0d expected %0d", ndone,
                   (ndone == 0) ? t : t - last_t, (ndone == 0) ? n + 3 : n + 4);
        end
        last_t = t;
        last_exp8 = exp[15:0];
        ndone++;
        if (ndone < 3) begin
          op_a = ta[ndone];
          op_b = tb[ndone];
          smode = ts[ndone];
        end
      end else if (product8 !== last_exp8) begin
        hold_err++;
      end
    end
    start = 1'b0;
    checks++;
    if (ndone != 3) begin
      errors++;
      $display("[TB] FAIL b2b_timeout: got %0d results expected 3", ndone);
    end
    checks++;
    if (hold_err != 0) begin
      errors++;
      $display("[TB] FAIL b2b_hold: got %0d changed cycles expected 0", hold_err);
    end
    repeat (2) @(posedge clk);
    #1;
  endtask

  task automatic test_width16();
    do_op(1'b1, 16'h8000, 16'h7FFF, 1'b1, 1'b0, "w16_s_min_x_max");
    for (int i = 0; i < 4; i++) begin
      do_op(1'b1, 16'($urandom), 16'($urandom), 1'($urandom_range(0, 1)), 1'b0, "w16_rand");
    end
  endtask

  task automatic test_random();
    logic [15:0] a;
    logic [15:0] b;
    bit sm;
    for (int i = 0; i < 24; i++) begin
      a = 16'($urandom_range(0, 255));
      sm = 1'($urandom_range(0, 1));
      case ($urandom_range(0, 4))
        0: b = 16'd0;
        1: b = 16'd1;
        2: b = 16'd255;
        3: b = 16'd128;
        default: b = 16'($urandom_range(0, 255));
      endcase
      do_op(1'b0, a, b, sm, 1'b0, "w8_rand");
    end
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    checks = 0;
    errors = 0;
    last_exp8 = '0;
    reset_n = 1'b0;
    start = 1'b0;
    sel16 = 1'b0;
    smode = 1'b0;
    op_a = '0;
    op_b = '0;
    repeat (3) @(posedge clk);
    #1;
    test_reset();
    reset_n = 1'b1;
    @(posedge clk); #1;
    test_unsigned_basic();
    test_signed();
    test_early_termination();
    test_reset_mid_op();
    test_handshake();
    test_back_to_back();
    test_width16();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
